// File: rtl/cv32e40x_pkg.sv
// Shared constants for the interrupt source stage: standard machine interrupt ids and the
// default set of implemented interrupt lines.
package cv32e40x_pkg;

  localparam int unsigned IRQ_W    = 32;
  localparam int unsigned IRQ_ID_W = 5;

  localparam logic [IRQ_ID_W-1:0] IRQ_ID_MEI = 5'd11;
  localparam logic [IRQ_ID_W-1:0] IRQ_ID_MSI = 5'd3;
  localparam logic [IRQ_ID_W-1:0] IRQ_ID_MTI = 5'd7;

  // MSI, MTI, MEI plus the 16 platform lines
  localparam logic [IRQ_W-1:0] IRQ_MASK_DEFAULT = 32'hFFFF_0888;

endpackage

// File: rtl/cv32e40x_irq_prio_enc.sv
// Fixed-priority interrupt encoder: MEI, then MSI, then MTI, then platform lines 31 down to 16.
// Purely combinational; lines outside that set never win.
module cv32e40x_irq_prio_enc
  import cv32e40x_pkg::*;
(
  input  logic [IRQ_W-1:0]    en,
  output logic [IRQ_ID_W-1:0] id,
  output logic                valid
);

  always_comb begin
    id    = '0;
    valid = 1'b0;
    // Each later assignment overrides an earlier one, so evaluate lowest priority first.
    for (int i = 16; i < 32; i++) begin
      if (en[i]) begin
        id    = IRQ_ID_W'(i);
        valid = 1'b1;
      end
    end
    if (en[IRQ_ID_MTI]) begin
      id    = IRQ_ID_MTI;
      valid = 1'b1;
    end
    if (en[IRQ_ID_MSI]) begin
      id    = IRQ_ID_MSI;
      valid = 1'b1;
    end
    if (en[IRQ_ID_MEI]) begin
      id    = IRQ_ID_MEI;
      valid = 1'b1;
    end
  end

endmodule

// File: rtl/cv32e40x_irq_sampler.sv
// Interrupt source stage: registers raw lines into mip (level or rising-edge per line),
// masks with mie / mstatus.MIE and presents one arbitrated request to the controller.
module cv32e40x_irq_sampler
  import cv32e40x_pkg::*;
#(
  parameter logic [IRQ_W-1:0] IRQ_EDGE_MASK  = 32'h0000_0000,
  parameter logic [IRQ_W-1:0] IRQ_VALID_MASK = IRQ_MASK_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [IRQ_W-1:0]    irq_i,
  input  logic [IRQ_W-1:0]    mie_i,
  input  logic                m_ie_i,
  input  logic                irq_ack_i,
  input  logic [IRQ_ID_W-1:0] irq_ack_id_i,
  output logic [IRQ_W-1:0]    mip_o,
  output logic                irq_req_ctrl_o,
  output logic [9:0]          irq_id_ctrl_o,
  output logic                irq_wu_ctrl_o
);

  localparam logic [IRQ_W-1:0] EDGE_LINES = IRQ_EDGE_MASK & IRQ_VALID_MASK;

  logic [IRQ_W-1:0]    irq_q;
  logic [IRQ_W-1:0]    pend_q;
  logic [IRQ_W-1:0]    edge_set;
  logic [IRQ_W-1:0]    ack_clr;
  logic [IRQ_W-1:0]    en;
  logic [IRQ_ID_W-1:0] win_id;
  logic                win_valid;

  // Rising edge is judged against the raw input so the pending bit appears with the same
  // one-cycle latency as a level line.
  assign edge_set = irq_i & ~irq_q & EDGE_LINES;
  assign ack_clr  = irq_ack_i ? (IRQ_W'(1) << irq_ack_id_i) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      irq_q  <= '0;
      pend_q <= '0;
    end else begin
      irq_q  <= irq_i & IRQ_VALID_MASK;
      pend_q <= ((pend_q & ~ack_clr) | edge_set) & EDGE_LINES;
    end
  end

  assign mip_o = (irq_q & ~EDGE_LINES) | pend_q;
  assign en    = mip_o & mie_i;

  cv32e40x_irq_prio_enc u_prio_enc (
    .en    (en),
    .id    (win_id),
    .valid (win_valid)
  );

  // Handshake: irq_req_ctrl_o/irq_id_ctrl_o act as valid/payload; irq_ack_i is a one-cycle
  // take strobe that may only be raised while irq_req_ctrl_o is high, and it clears the
  // pending bit of an edge line named by irq_ack_id_i (level lines clear at the source).
  assign irq_wu_ctrl_o  = win_valid;
  assign irq_req_ctrl_o = win_valid & m_ie_i;
  assign irq_id_ctrl_o  = {5'b0, win_id};

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(irq_ack_i && !irq_req_ctrl_o));
    end
  end

endmodule

// File: tb/tb_cv32e40x_irq_sampler.sv
// Directed bench for the interrupt source stage; line 16 is configured rising-edge sensitive.
module tb_cv32e40x_irq_sampler;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] irq_i;
  logic [31:0] mie_i;
  logic        m_ie_i;
  logic        irq_ack_i;
  logic [4:0]  irq_ack_id_i;
  logic [31:0] mip_o;
  logic        irq_req_ctrl_o;
  logic [9:0]  irq_id_ctrl_o;
  logic        irq_wu_ctrl_o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cv32e40x_irq_sampler #(
    .IRQ_EDGE_MASK  (32'h0001_0000),
    .IRQ_VALID_MASK (32'hFFFF_0888)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .irq_i          (irq_i),
    .mie_i          (mie_i),
    .m_ie_i         (m_ie_i),
    .irq_ack_i      (irq_ack_i),
    .irq_ack_id_i   (irq_ack_id_i),
    .mip_o          (mip_o),
    .irq_req_ctrl_o (irq_req_ctrl_o),
    .irq_id_ctrl_o  (irq_id_ctrl_o),
    .irq_wu_ctrl_o  (irq_wu_ctrl_o)
  );

  // Advance one active edge and settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst          = 1'b1;
    irq_i        = 32'hFFFF_FFFF;
    mie_i        = 32'hFFFF_FFFF;
    m_ie_i       = 1'b1;
    irq_ack_i    = 1'b0;
    irq_ack_id_i = 5'd0;

    // Reset hold
    step();
    step();
    step();
    check("rst_mip", mip_o, 32'h0);
    check("rst_req", 32'(irq_req_ctrl_o), 32'h0);
    check("rst_wu", 32'(irq_wu_ctrl_o), 32'h0);
    check("rst_id", 32'(irq_id_ctrl_o), 32'h0);

    irq_i = 32'h0;
    step();
    rst = 1'b0;
    step();
    check("idle_mip", mip_o, 32'h0);

    // Level MTI
    irq_i = 32'h0000_0080;
    mie_i = 32'h0000_0080;
    #1;
    check("mti_no_comb_path", 32'(irq_req_ctrl_o), 32'h0);
    step();
    check("mti_req", 32'(irq_req_ctrl_o), 32'h1);
    check("mti_id", 32'(irq_id_ctrl_o), 32'd7);
    check("mti_mip", mip_o, 32'h0000_0080);
    irq_i = 32'h0;
    step();
    check("mti_drop_req", 32'(irq_req_ctrl_o), 32'h0);
    check("mti_drop_id", 32'(irq_id_ctrl_o), 32'h0);

    // Priority
    mie_i = 32'hFFFF_FFFF;
    irq_i = 32'h0010_0888;
    step();
    check("prio_mip", mip_o, 32'h0010_0888);
    check("prio_mei", 32'(irq_id_ctrl_o), 32'd11);
    irq_i = 32'h0010_0088;
    step();
    check("prio_msi", 32'(irq_id_ctrl_o), 32'd3);
    irq_i = 32'h0010_0080;
    step();
    check("prio_mti", 32'(irq_id_ctrl_o), 32'd7);
    irq_i = 32'h0010_0000;
    step();
    check("prio_p20", 32'(irq_id_ctrl_o), 32'd20);
    irq_i = 32'h0018_0000;
    step();
    check("prio_p20_over_p19", 32'(irq_id_ctrl_o), 32'd20);
    irq_i = 32'h0;
    step();
    check("prio_idle_req", 32'(irq_req_ctrl_o), 32'h0);

    // Edge line 16
    mie_i = 32'h0001_0000;
    irq_i = 32'h0001_0000;
    step();
    check("edge_set_mip", mip_o, 32'h0001_0000);
    irq_i = 32'h0;
    step();
    check("edge_hold_mip", mip_o, 32'h0001_0000);
    check("edge_hold_id", 32'(irq_id_ctrl_o), 32'd16);
    irq_ack_i    = 1'b1;
    irq_ack_id_i = 5'd5;
    step();
    irq_ack_i = 1'b0;
    check("edge_foreign_ack", mip_o, 32'h0001_0000);
    irq_ack_i    = 1'b1;
    irq_ack_id_i = 5'd16;
    step();
    irq_ack_i = 1'b0;
    check("edge_ack_clear", mip_o, 32'h0);
    check("edge_ack_req", 32'(irq_req_ctrl_o), 32'h0);
    irq_i = 32'h0001_0000;
    step();
    irq_i = 32'h0;
    step();
    check("edge_repend", mip_o, 32'h0001_0000);
    irq_i     = 32'h0001_0000;
    irq_ack_i = 1'b1;
    step();
    irq_ack_i = 1'b0;
    check("edge_set_wins", mip_o, 32'h0001_0000);
    irq_i     = 32'h0;
    irq_ack_i = 1'b1;
    step();
    irq_ack_i = 1'b0;
    check("edge_final_clear", mip_o, 32'h0);

    // Wake-up without global enable
    m_ie_i = 1'b0;
    irq_i  = 32'h0000_0800;
    mie_i  = 32'h0000_0800;
    step();
    check("wu_wake", 32'(irq_wu_ctrl_o), 32'h1);
    check("wu_no_req", 32'(irq_req_ctrl_o), 32'h0);
    check("wu_id", 32'(irq_id_ctrl_o), 32'd11);
    m_ie_i = 1'b1;
    #1;
    check("wu_mie_same_cycle", 32'(irq_req_ctrl_o), 32'h1);
    irq_i = 32'h0;
    step();

    // Unimplemented and masked lines
    irq_i = 32'h0010_0020;
    mie_i = 32'hFFEF_FFFF;
    step();
    check("unimpl_mip", mip_o, 32'h0010_0000);
    check("masked_wu", 32'(irq_wu_ctrl_o), 32'h0);
    check("masked_req", 32'(irq_req_ctrl_o), 32'h0);
    irq_i = 32'h0;
    step();

    // Reset discards a pending edge; a line held high is re-detected after release
    mie_i = 32'hFFFF_FFFF;
    irq_i = 32'h0001_0000;
    step();
    check("rst_mid_pend", mip_o, 32'h0001_0000);
    rst = 1'b1;
    step();
    check("rst_mid_discard", mip_o, 32'h0);
    rst = 1'b0;
    step();
    check("rst_held_edge", mip_o, 32'h0001_0000);
    check("rst_held_id", 32'(irq_id_ctrl_o), 32'd16);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
